// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and widths for the systolic-array load sequencer
package sa_pkg;
    typedef enum logic [2:0] {IDLE, FILL, WRROW, COMPUTE, DONE} seq_state_t;
    localparam int SA_DW    = 16;
    localparam int SA_LANES = 16;
    localparam int SA_IDXW  = 5;
endpackage

// File: rtl/sa_load_sequencer_if.sv
// rtl/sa_load_sequencer_if.sv - word stream in, row/control bus out of the load sequencer
interface sa_load_sequencer_if;
    import sa_pkg::*;
    logic               start;
    logic [SA_DW-1:0]   s_data;
    logic               s_valid;
    logic               s_ready;
    logic               en;
    logic               rf_en;
    logic               write;
    logic [SA_IDXW-1:0] idx;
    logic [SA_DW-1:0]   din [SA_LANES];
    logic               busy;
    logic               done;

    modport master (output start, s_data, s_valid,
                    input  s_ready, en, rf_en, write, idx, din, busy, done);
    modport slave  (input  start, s_data, s_valid,
                    output s_ready, en, rf_en, write, idx, din, busy, done);
endinterface

// File: rtl/sa_row_packer.sv
// rtl/sa_row_packer.sv - packs 16 accepted stream words into one row buffer
module sa_row_packer
    import sa_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_ready,
    input  logic             i_valid,
    input  logic [SA_DW-1:0] i_data,
    output logic             o_full,
    output logic [SA_DW-1:0] o_row [SA_LANES]
);
    logic [3:0]       r_word_cnt;
    logic [SA_DW-1:0] r_buf [SA_LANES];
    logic             w_accept;

    assign w_accept = i_ready & i_valid;
    assign o_full   = w_accept && (r_word_cnt == 4'd15);
    assign o_row    = r_buf;

    // word_cnt only wraps on the 16th accept, which is also the row-complete event
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word_cnt <= '0;
            for (int k = 0; k < SA_LANES; k++) r_buf[k] <= '0;
        end else if (i_clear) begin
            r_word_cnt <= '0;
            for (int k = 0; k < SA_LANES; k++) r_buf[k] <= '0;
        end else if (w_accept) begin
            r_buf[r_word_cnt] <= i_data;
            r_word_cnt        <= r_word_cnt + 4'd1;
        end
    end
endmodule

// File: rtl/sa_load_sequencer.sv
// rtl/sa_load_sequencer.sv - loads NUM_ROWS packed rows into the array, then runs compute
module sa_load_sequencer
    import sa_pkg::*;
#(
    parameter int NUM_ROWS       = 32,
    parameter int WR_HOLD        = 2,
    parameter int COMPUTE_CYCLES = 22
)
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    sa_load_sequencer_if.slave bus
);
    localparam int HW = $clog2(WR_HOLD) + 1;
    localparam int CW = $clog2(COMPUTE_CYCLES) + 1;
    localparam logic [HW-1:0]      HOLD_LAST = HW'(WR_HOLD - 1);
    localparam logic [CW-1:0]      CMP_LAST  = CW'(COMPUTE_CYCLES - 1);
    localparam logic [SA_IDXW-1:0] ROW_LAST  = SA_IDXW'(NUM_ROWS - 1);

    seq_state_t         r_state, w_next;
    logic [SA_IDXW-1:0] r_row_cnt;
    logic [HW-1:0]      r_hold_cnt;
    logic [CW-1:0]      r_cmp_cnt;
    logic               r_en, r_rf_en, r_write, r_busy, r_done;
    logic               w_ready, w_full, w_clear;
    logic [SA_DW-1:0]   w_row [SA_LANES];

    assign w_ready = (r_state == FILL);
    assign w_clear = (r_state == IDLE) && bus.start;

    sa_row_packer u_packer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_clear),
        .i_ready (w_ready),
        .i_valid (bus.s_valid),
        .i_data  (bus.s_data),
        .o_full  (w_full),
        .o_row   (w_row)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = FILL;
            FILL:    if (w_full) w_next = WRROW;
            WRROW:   if (r_hold_cnt == HOLD_LAST)
                         w_next = (r_row_cnt == ROW_LAST) ? COMPUTE : FILL;
            COMPUTE: if (r_cmp_cnt == CMP_LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they change with the state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_row_cnt  <= '0;
            r_hold_cnt <= '0;
            r_cmp_cnt  <= '0;
            r_en       <= 1'b0;
            r_rf_en    <= 1'b0;
            r_write    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_en       <= (w_next == WRROW) || (w_next == COMPUTE);
            r_rf_en    <= (w_next == WRROW) || (w_next == COMPUTE);
            r_write    <= (w_next == WRROW);
            r_busy     <= (w_next != IDLE);
            r_done     <= (w_next == DONE);
            r_hold_cnt <= (r_state == WRROW && w_next == WRROW) ? r_hold_cnt + 1'b1 : '0;
            r_cmp_cnt  <= (r_state == COMPUTE && w_next == COMPUTE) ? r_cmp_cnt + 1'b1 : '0;
            if (w_clear)
                r_row_cnt <= '0;
            else if (r_state == WRROW && w_next == FILL)
                r_row_cnt <= r_row_cnt + 1'b1;
        end
    end

    assign bus.s_ready = w_ready;
    assign bus.en      = r_en;
    assign bus.rf_en   = r_rf_en;
    assign bus.write   = r_write;
    assign bus.idx     = r_row_cnt;
    assign bus.din     = w_row;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule
